// File: rtl/gen_crd_rtn_top.sv
`default_nettype none
// ============================================================================
// Module      : gen_crd_rtn_top
// Description : Receiver-side credit returner. Tracks buffer occupancy from
//               sender credit use, coalesces freed entries and grants them
//               back to the sender; flags overflow/underflow violations.
// Revision    : 1.0 - initial release
// ============================================================================
module gen_crd_rtn_top #(
    parameter int CRD_INIT_AMOUNT  = 8,
    parameter int MAX_CRD_USED_VAL = 1,
    parameter int MAX_CRD_FREE_VAL = 1,
    parameter int MAX_CRD_GRNT_VAL = 1,
    parameter int RTN_THRESH       = 1,
    parameter int RTN_TIMEOUT      = 16,
    localparam int CRD_CNT_W  = $clog2(CRD_INIT_AMOUNT) + 1,
    localparam int CRD_USED_W = $clog2(MAX_CRD_USED_VAL) + 1,
    localparam int CRD_FREE_W = $clog2(MAX_CRD_FREE_VAL) + 1,
    localparam int CRD_GRNT_W = $clog2(MAX_CRD_GRNT_VAL) + 1,
    localparam int TMR_W      = $clog2(RTN_TIMEOUT + 1) + 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [CRD_USED_W-1:0] crd_used_val,
    input  logic                  crd_used_en,
    input  logic [CRD_FREE_W-1:0] crd_free_val,
    input  logic                  crd_free_en,
    input  logic                  crd_rtn_hold,
    input  logic                  err_clr,
    output logic [CRD_GRNT_W-1:0] crd_grnt_val,
    output logic                  crd_grnt_en,
    output logic [CRD_CNT_W-1:0]  crd_pend,
    output logic [CRD_CNT_W-1:0]  occ,
    output logic                  idle,
    output logic                  ovf_err,
    output logic                  udf_err
);

    // Common arithmetic width wide enough for occ + used without wrap.
    localparam int c_W0    = (CRD_CNT_W > CRD_USED_W) ? CRD_CNT_W : CRD_USED_W;
    localparam int c_SUM_W = ((c_W0 > CRD_FREE_W) ? c_W0 : CRD_FREE_W) + 1;

    localparam logic [c_SUM_W-1:0] c_INIT      = c_SUM_W'(CRD_INIT_AMOUNT);
    localparam logic [c_SUM_W-1:0] c_GRNT_MAX  = c_SUM_W'(MAX_CRD_GRNT_VAL);
    localparam logic [c_SUM_W-1:0] c_THRESH    = c_SUM_W'(RTN_THRESH);

    logic [CRD_CNT_W-1:0]  r_occ;
    logic [CRD_CNT_W-1:0]  r_pend;
    logic                  r_grnt_en;
    logic [CRD_GRNT_W-1:0] r_grnt_val;
    logic                  r_ovf;
    logic                  r_udf;

    logic [c_SUM_W-1:0] w_used;
    logic [c_SUM_W-1:0] w_free_req;
    logic [c_SUM_W-1:0] w_occ_x;
    logic [c_SUM_W-1:0] w_pend_x;
    logic [c_SUM_W-1:0] w_eff_free;
    logic [c_SUM_W-1:0] w_occ_sum;
    logic [c_SUM_W-1:0] w_occ_next;
    logic [c_SUM_W-1:0] w_grnt_amt;
    logic [c_SUM_W-1:0] w_pend_next;
    logic               w_udf;
    logic               w_ovf;
    logic               w_pend_zero;
    logic               w_tmo;
    logic               w_fire;

    assign w_used     = crd_used_en ? c_SUM_W'(crd_used_val) : '0;
    assign w_free_req = crd_free_en ? c_SUM_W'(crd_free_val) : '0;
    assign w_occ_x    = c_SUM_W'(r_occ);
    assign w_pend_x   = c_SUM_W'(r_pend);

    // Only entries already resident can be freed; the excess is a violation.
    assign w_udf      = (w_free_req > w_occ_x);
    assign w_eff_free = w_udf ? w_occ_x : w_free_req;

    assign w_occ_sum  = w_occ_x + w_used;
    assign w_ovf      = (w_occ_sum > c_INIT);
    assign w_occ_next = (w_ovf ? c_INIT : w_occ_sum) - w_eff_free;

    assign w_pend_zero = (r_pend == '0);
    assign w_fire      = !crd_rtn_hold && !w_pend_zero &&
                         ((w_pend_x >= c_THRESH) || w_tmo);
    assign w_grnt_amt  = (w_pend_x > c_GRNT_MAX) ? c_GRNT_MAX : w_pend_x;
    assign w_pend_next = w_pend_x - (w_fire ? w_grnt_amt : '0) + w_eff_free;

    generate
        if (RTN_TIMEOUT != 0) begin : g_tmr
            localparam logic [TMR_W-1:0] c_TMR_MAX = TMR_W'(RTN_TIMEOUT - 1);
            logic [TMR_W-1:0] r_tmr;

            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    r_tmr <= '0;
                end else if (w_fire || w_pend_zero) begin
                    r_tmr <= '0;
                end else if (!crd_rtn_hold && (r_tmr != c_TMR_MAX)) begin
                    r_tmr <= r_tmr + 1'b1;
                end
            end

            assign w_tmo = (r_tmr == c_TMR_MAX);
        end else begin : g_no_tmr
            assign w_tmo = 1'b0;
        end
    endgenerate

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_occ      <= '0;
            r_pend     <= '0;
            r_grnt_en  <= 1'b0;
            r_grnt_val <= '0;
            r_ovf      <= 1'b0;
            r_udf      <= 1'b0;
        end else begin
            r_occ      <= CRD_CNT_W'(w_occ_next);
            r_pend     <= CRD_CNT_W'(w_pend_next);
            r_grnt_en  <= w_fire;
            r_grnt_val <= w_fire ? CRD_GRNT_W'(w_grnt_amt) : '0;
            // A new violation outranks a simultaneous clear.
            r_ovf      <= w_ovf || (r_ovf && !err_clr);
            r_udf      <= w_udf || (r_udf && !err_clr);
        end
    end

    assign crd_grnt_val = r_grnt_val;
    assign crd_grnt_en  = r_grnt_en;
    assign crd_pend     = r_pend;
    assign occ          = r_occ;
    assign idle         = (r_occ == '0) && w_pend_zero && !r_grnt_en;
    assign ovf_err      = r_ovf;
    assign udf_err      = r_udf;

endmodule
`default_nettype wire

// File: tb/tb_gen_crd_rtn_top.sv
`default_nettype none
// ============================================================================
// Module      : tb_gen_crd_rtn_top
// Description : Directed self-checking bench; three parameterisations of the
//               credit returner driven from one clock and reset.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_gen_crd_rtn_top;

    logic clk;
    logic rst;
    int   n_vec;
    int   n_miscmp;

    // Instance A: all defaults
    logic       a_used_val, a_used_en, a_free_val, a_free_en, a_hold, a_clr;
    logic       a_grnt_val, a_grnt_en, a_idle, a_ovf, a_udf;
    logic [3:0] a_pend, a_occ;

    // Instance B: THRESH 4, grant/free/used 4
    logic [2:0] b_used_val, b_free_val, b_grnt_val;
    logic       b_used_en, b_free_en, b_hold, b_clr;
    logic       b_grnt_en, b_idle, b_ovf, b_udf;
    logic [3:0] b_pend, b_occ;

    // Instance C: grant 2, free 8, used 9
    logic [4:0] c_used_val;
    logic [3:0] c_free_val;
    logic [1:0] c_grnt_val;
    logic       c_used_en, c_free_en, c_hold, c_clr;
    logic       c_grnt_en, c_idle, c_ovf, c_udf;
    logic [3:0] c_pend, c_occ;

    gen_crd_rtn_top u_dut_a (
        .clk(clk), .rst(rst),
        .crd_used_val(a_used_val), .crd_used_en(a_used_en),
        .crd_free_val(a_free_val), .crd_free_en(a_free_en),
        .crd_rtn_hold(a_hold), .err_clr(a_clr),
        .crd_grnt_val(a_grnt_val), .crd_grnt_en(a_grnt_en),
        .crd_pend(a_pend), .occ(a_occ), .idle(a_idle),
        .ovf_err(a_ovf), .udf_err(a_udf)
    );

    gen_crd_rtn_top #(
        .MAX_CRD_USED_VAL(4), .MAX_CRD_FREE_VAL(4), .MAX_CRD_GRNT_VAL(4),
        .RTN_THRESH(4), .RTN_TIMEOUT(16)
    ) u_dut_b (
        .clk(clk), .rst(rst),
        .crd_used_val(b_used_val), .crd_used_en(b_used_en),
        .crd_free_val(b_free_val), .crd_free_en(b_free_en),
        .crd_rtn_hold(b_hold), .err_clr(b_clr),
        .crd_grnt_val(b_grnt_val), .crd_grnt_en(b_grnt_en),
        .crd_pend(b_pend), .occ(b_occ), .idle(b_idle),
        .ovf_err(b_ovf), .udf_err(b_udf)
    );

    gen_crd_rtn_top #(
        .MAX_CRD_USED_VAL(9), .MAX_CRD_FREE_VAL(8), .MAX_CRD_GRNT_VAL(2),
        .RTN_THRESH(1), .RTN_TIMEOUT(16)
    ) u_dut_c (
        .clk(clk), .rst(rst),
        .crd_used_val(c_used_val), .crd_used_en(c_used_en),
        .crd_free_val(c_free_val), .crd_free_en(c_free_en),
        .crd_rtn_hold(c_hold), .err_clr(c_clr),
        .crd_grnt_val(c_grnt_val), .crd_grnt_en(c_grnt_en),
        .crd_pend(c_pend), .occ(c_occ), .idle(c_idle),
        .ovf_err(c_ovf), .udf_err(c_udf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_miscmp++;
            $display("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Advance past the next active edge and settle.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        n_vec = 0;
        n_miscmp = 0;
        rst = 1'b1;
        a_used_val = '0; a_used_en = 0; a_free_val = '0; a_free_en = 0; a_hold = 0; a_clr = 0;
        b_used_val = '0; b_used_en = 0; b_free_val = '0; b_free_en = 0; b_hold = 0; b_clr = 0;
        c_used_val = '0; c_used_en = 0; c_free_val = '0; c_free_en = 0; c_hold = 0; c_clr = 0;
        repeat (3) step();
        rst = 1'b0;
        step();

        // Reset state
        chk("rst_occ",   32'(a_occ), 0);
        chk("rst_pend",  32'(a_pend), 0);
        chk("rst_gen",   32'(a_grnt_en), 0);
        chk("rst_gval",  32'(a_grnt_val), 0);
        chk("rst_idle",  32'(a_idle), 1);
        chk("rst_ovf",   32'(a_ovf), 0);
        chk("rst_udf",   32'(a_udf), 0);

        // A: three single uses, then frees in N, N+1, N+2
        a_used_en = 1; a_used_val = 1;
        repeat (3) step();
        a_used_en = 0; a_used_val = 0;
        chk("a_occ3",  32'(a_occ), 3);
        chk("a_busy",  32'(a_idle), 0);
        a_free_en = 1; a_free_val = 1;
        step();                                     // cycle N+1
        chk("a_n1_pend", 32'(a_pend), 1);
        chk("a_n1_occ",  32'(a_occ), 2);
        chk("a_n1_gen",  32'(a_grnt_en), 0);
        step();                                     // cycle N+2
        chk("a_n2_gen",  32'(a_grnt_en), 1);
        chk("a_n2_gval", 32'(a_grnt_val), 1);
        chk("a_n2_pend", 32'(a_pend), 1);
        chk("a_n2_occ",  32'(a_occ), 1);
        step();                                     // cycle N+3
        a_free_en = 0; a_free_val = 0;
        chk("a_n3_gen",  32'(a_grnt_en), 1);
        chk("a_n3_gval", 32'(a_grnt_val), 1);
        chk("a_n3_occ",  32'(a_occ), 0);
        step();                                     // cycle N+4
        chk("a_n4_gen",  32'(a_grnt_en), 1);
        chk("a_n4_gval", 32'(a_grnt_val), 1);
        chk("a_n4_pend", 32'(a_pend), 0);
        step();                                     // cycle N+5
        chk("a_n5_gen",  32'(a_grnt_en), 0);
        chk("a_n5_idle", 32'(a_idle), 1);

        // A: underflow, sticky, error wins over clear, then clear
        a_free_en = 1; a_free_val = 1;
        step();
        a_free_en = 0; a_free_val = 0;
        chk("a_udf_set",  32'(a_udf), 1);
        chk("a_udf_occ",  32'(a_occ), 0);
        chk("a_udf_pend", 32'(a_pend), 0);
        step();
        chk("a_udf_stky", 32'(a_udf), 1);
        a_free_en = 1; a_free_val = 1; a_clr = 1;
        step();
        a_free_en = 0; a_free_val = 0;
        chk("a_udf_wins", 32'(a_udf), 1);

        // B: occ 4, one free of 4 -> one grant of 4 two cycles later
        b_used_en = 1; b_used_val = 4;
        step();
        a_clr = 0;
        chk("a_udf_clr", 32'(a_udf), 0);
        b_used_en = 0; b_used_val = 0;
        chk("b_occ4", 32'(b_occ), 4);
        b_free_en = 1; b_free_val = 4;
        step();                                     // N+1
        b_free_en = 0; b_free_val = 0;
        chk("b_n1_pend", 32'(b_pend), 4);
        chk("b_n1_occ",  32'(b_occ), 0);
        chk("b_n1_gen",  32'(b_grnt_en), 0);
        step();                                     // N+2
        chk("b_n2_gen",  32'(b_grnt_en), 1);
        chk("b_n2_gval", 32'(b_grnt_val), 4);
        chk("b_n2_pend", 32'(b_pend), 0);
        step();                                     // N+3
        chk("b_n3_gen",  32'(b_grnt_en), 0);
        chk("b_n3_idle", 32'(b_idle), 1);

        // B: single free below threshold -> forced return at N+17
        b_used_en = 1; b_used_val = 1;
        step();
        b_used_en = 0; b_used_val = 0;
        b_free_en = 1; b_free_val = 1;
        step();                                     // N+1
        b_free_en = 0; b_free_val = 0;
        chk("b_to_pend", 32'(b_pend), 1);
        for (int k = 2; k <= 16; k++) begin
            step();
            chk($sformatf("b_to_wait%0d", k), 32'(b_grnt_en), 0);
        end
        step();                                     // N+17
        chk("b_to_gen",  32'(b_grnt_en), 1);
        chk("b_to_gval", 32'(b_grnt_val), 1);
        step();
        chk("b_to_done", 32'(b_grnt_en), 0);
        chk("b_to_pend0", 32'(b_pend), 0);

        // C: pend 5 at once, grants 2,2,1 capped at 2, paused by hold
        c_used_en = 1; c_used_val = 5;
        step();
        c_used_en = 0; c_used_val = 0;
        c_free_en = 1; c_free_val = 5;
        step();                                     // N+1
        c_free_en = 0; c_free_val = 0;
        chk("c_n1_pend", 32'(c_pend), 5);
        step();                                     // N+2
        chk("c_n2_gen",  32'(c_grnt_en), 1);
        chk("c_n2_gval", 32'(c_grnt_val), 2);
        chk("c_n2_pend", 32'(c_pend), 3);
        c_hold = 1;
        step();                                     // N+3
        chk("c_h1_gen",  32'(c_grnt_en), 0);
        chk("c_h1_pend", 32'(c_pend), 3);
        step();                                     // N+4
        chk("c_h2_gen",  32'(c_grnt_en), 0);
        c_hold = 0;
        step();                                     // N+5
        chk("c_n5_gen",  32'(c_grnt_en), 1);
        chk("c_n5_gval", 32'(c_grnt_val), 2);
        chk("c_n5_pend", 32'(c_pend), 1);
        step();                                     // N+6
        chk("c_n6_gen",  32'(c_grnt_en), 1);
        chk("c_n6_gval", 32'(c_grnt_val), 1);
        chk("c_n6_pend", 32'(c_pend), 0);
        step();
        chk("c_n7_gen",  32'(c_grnt_en), 0);
        chk("c_n7_idle", 32'(c_idle), 1);

        // C: used 9 against depth 8 -> overflow, occ clamped at 8
        c_used_en = 1; c_used_val = 9;
        step();
        c_used_en = 0; c_used_val = 0;
        chk("c_ovf_set", 32'(c_ovf), 1);
        chk("c_ovf_occ", 32'(c_occ), 8);
        chk("c_ovf_udf", 32'(c_udf), 0);
        step();
        chk("c_ovf_stky", 32'(c_ovf), 1);
        c_clr = 1;
        step();
        c_clr = 0;
        chk("c_ovf_clr", 32'(c_ovf), 0);
        chk("c_ovf_occ8", 32'(c_occ), 8);

        // Asynchronous reset mid-operation
        rst = 1'b1;
        #1;
        chk("c_arst_occ",  32'(c_occ), 0);
        chk("c_arst_idle", 32'(c_idle), 1);
        step();
        rst = 1'b0;
        step();
        chk("c_post_occ", 32'(c_occ), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miscmp);
        $finish;
    end

endmodule
`default_nettype wire
